luhn_stream_checker: RTL and testbench

LUHN_STREAM_CHECKER -- requirements
Module: luhn_stream_checker

---
 rtl/luhn_pkg.sv | 30 +++
 rtl/luhn_digit_dbl.sv | 16 +
 rtl/luhn_stream_checker.sv | 179 +++++++++++++++++
 tb/tb_luhn_stream_checker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/luhn_pkg.sv
// rtl/luhn_pkg.sv - shared state, mode and error encodings for the Luhn stream checker
package luhn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_FINISH = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        MODE_VERIFY   = 1'b0,
        MODE_GENERATE = 1'b1
    } mode_t;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_BAD_DIGIT = 2'd1;
    localparam logic [1:0] ERR_TOO_SHORT = 2'd2;
    localparam logic [1:0] ERR_TOO_LONG  = 2'd3;

    // Operands are both 0..9, so a single conditional subtract keeps the result mod 10.
    function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic [4:0] t;
        s = {1'b0, a} + {1'b0, b};
        t = s - 5'd10;
        return (s >= 5'd10) ? t[3:0] : s[3:0];
    endfunction

endpackage

// File: rtl/luhn_digit_dbl.sv
// rtl/luhn_digit_dbl.sv - Luhn doubling of one BCD digit: 2d, folded to 2d-9 above 4
module luhn_digit_dbl (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    logic [4:0] twice;
    logic [4:0] folded;

    always_comb begin
        twice  = {din, 1'b0};
        folded = twice - 5'd9;
        dout   = (din <= 4'd4) ? twice[3:0] : folded[3:0];
    end

endmodule

// File: rtl/luhn_stream_checker.sv
// rtl/luhn_stream_checker.sv - streaming Luhn verifier / check-digit generator
module luhn_stream_checker
    import luhn_pkg::*;
#(
    parameter  int MAX_DIGITS = 19,
    parameter  int MIN_DIGITS = 2,
    localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             start,
    input  logic             mode,
    input  logic [3:0]       digit,
    input  logic             digit_valid,
    input  logic             digit_last,
    output logic             digit_ready,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic [3:0]       check_digit,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] digit_count
);

    localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_DIGITS - 1);
    localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_DIGITS - 1);

    state_t            state_q,    state_d;
    mode_t             mode_q,     mode_d;
    logic [3:0]        sum_e_q,    sum_e_d;
    logic [3:0]        sum_o_q,    sum_o_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic              ready_q,    ready_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              valid_q,    valid_d;
    logic [3:0]        check_q,    check_d;
    logic              error_q,    error_d;
    logic [1:0]        err_code_q, err_code_d;

    logic [3:0] dbl_e;
    logic [3:0] dbl_o;

    luhn_digit_dbl u_dbl_e (.din(digit), .dout(dbl_e));
    luhn_digit_dbl u_dbl_o (.din(digit), .dout(dbl_o));

    logic       accept;
    logic       idx_even;
    logic       n_even;
    logic [3:0] sel_verify;
    logic [3:0] sel_gen;
    logic       err_hit;
    logic [1:0] err_sel;

    always_comb begin
        accept     = digit_valid & ready_q & ~start;
        idx_even   = ~count_q[0];
        // count_q already holds N once in FINISH, so its parity picks the sum
        // whose doubled positions sit one left of the check digit.
        n_even     = ~count_q[0];
        sel_verify = n_even ? sum_e_q : sum_o_q;
        sel_gen    = n_even ? sum_o_q : sum_e_q;
        err_hit    = 1'b0;
        err_sel    = ERR_NONE;

        state_d    = state_q;
        mode_d     = mode_q;
        sum_e_d    = sum_e_q;
        sum_o_d    = sum_o_q;
        count_d    = count_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = done_q;
        valid_d    = valid_q;
        check_d    = check_q;
        error_d    = error_q;
        err_code_d = err_code_q;

        if (start) begin
            state_d    = ST_ACCUM;
            mode_d     = mode_t'(mode);
            sum_e_d    = 4'd0;
            sum_o_d    = 4'd0;
            count_d    = '0;
            ready_d    = 1'b1;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            valid_d    = 1'b0;
            check_d    = 4'd0;
            error_d    = 1'b0;
            err_code_d = ERR_NONE;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        sum_e_d = add_mod10(sum_e_q, idx_even ? dbl_e : digit);
                        sum_o_d = add_mod10(sum_o_q, idx_even ? digit : dbl_o);
                        count_d = count_q + CNT_W'(1);
                        if (digit > 4'd9) begin
                            err_hit = 1'b1;
                            err_sel = ERR_BAD_DIGIT;
                        end else if (digit_last && (count_q < MIN_M1)) begin
                            err_hit = 1'b1;
                            err_sel = ERR_TOO_SHORT;
                        end else if (!digit_last && (count_q == MAX_M1)) begin
                            err_hit = 1'b1;
                            err_sel = ERR_TOO_LONG;
                        end
                        if (err_hit) begin
                            state_d    = ST_DONE;
                            ready_d    = 1'b0;
                            busy_d     = 1'b0;
                            done_d     = 1'b1;
                            error_d    = 1'b1;
                            err_code_d = err_sel;
                        end else if (digit_last) begin
                            state_d = ST_FINISH;
                            ready_d = 1'b0;
                        end
                    end
                end
                ST_FINISH: begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (mode_q == MODE_VERIFY) begin
                        valid_d = (sel_verify == 4'd0);
                        check_d = 4'd0;
                    end else begin
                        valid_d = 1'b0;
                        check_d = (sel_gen == 4'd0) ? 4'd0 : 4'd10 - sel_gen;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_VERIFY;
            sum_e_q    <= 4'd0;
            sum_o_q    <= 4'd0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            check_q    <= 4'd0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            sum_e_q    <= sum_e_d;
            sum_o_q    <= sum_o_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            check_q    <= check_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    assign digit_ready = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign valid       = valid_q;
    assign check_digit = check_q;
    assign error       = error_q;
    assign err_code    = err_code_q;
    assign digit_count = count_q;

endmodule

// File: tb/tb_luhn_stream_checker.sv
// tb/tb_luhn_stream_checker.sv - randomized and directed bench for luhn_stream_checker
module tb_luhn_stream_checker;

    localparam int MAX_DIGITS = 19;
    localparam int MIN_DIGITS = 2;
    localparam int CNT_W      = $clog2(MAX_DIGITS + 1);

    logic             CLOCK_50    = 1'b0;
    logic             RESET_N     = 1'b0;
    logic             start       = 1'b0;
    logic             mode        = 1'b0;
    logic [3:0]       digit       = 4'd0;
    logic             digit_valid = 1'b0;
    logic             digit_last  = 1'b0;
    logic             digit_ready;
    logic             busy;
    logic             done;
    logic             valid;
    logic [3:0]       check_digit;
    logic             error;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] digit_count;

    int checks = 0;
    int errors = 0;

    luhn_stream_checker #(.MAX_DIGITS(MAX_DIGITS), .MIN_DIGITS(MIN_DIGITS)) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .start       (start),
        .mode        (mode),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_last  (digit_last),
        .digit_ready (digit_ready),
        .busy        (busy),
        .done        (done),
        .valid       (valid),
        .check_digit (check_digit),
        .error       (error),
        .err_code    (err_code),
        .digit_count (digit_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Luhn weighting counted from the right-hand end of the digit string.
    function automatic int ref_weighted_sum(input int ds[$], input bit double_rightmost);
        int total = 0;
        for (int j = 0; j < ds.size(); j++) begin
            int d = ds[ds.size() - 1 - j];
            bit dbl = double_rightmost ? (j % 2 == 0) : (j % 2 == 1);
            if (dbl) begin
                d = d * 2;
                if (d > 9) d = d - 9;
            end
            total += d;
        end
        return total;
    endfunction

    function automatic logic [15:0] all_outs();
        return {digit_ready, busy, done, valid, check_digit, error, err_code, 5'(digit_count)};
    endfunction

    task automatic do_start(input bit m);
        start = 1'b1;
        mode  = m;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        start = 1'b0;
        mode  = 1'($urandom);
        check_eq("start_done", done, 0);
        check_eq("start_error", error, 0);
        check_eq("start_valid", valid, 0);
        check_eq("start_busy", busy, 1);
        check_eq("start_ready", digit_ready, 1);
        check_eq("start_count", digit_count, 0);
    endtask

    task automatic send_digit(input logic [3:0] d, input bit last);
        int n;
        repeat ($urandom_range(0, 2)) begin
            digit_last = 1'($urandom);
            @(negedge CLOCK_50);
        end
        digit       = d;
        digit_last  = last;
        digit_valid = 1'b1;
        n = 0;
        while (!digit_ready && n < 20) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (!digit_ready) check_eq("ready_timeout", 0, 1);
        else @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        digit_valid = 1'b0;
        digit_last  = 1'b0;
        digit       = 4'($urandom);
    endtask

    task automatic send_stream(input int ds[$]);
        for (int i = 0; i < ds.size(); i++)
            send_digit(4'(ds[i]), i == ds.size() - 1);
    endtask

    // Called on the negedge right after the last digit was accepted.
    task automatic finish_checks(input bit m, input int ds[$]);
        logic       exp_valid;
        logic [3:0] exp_check;
        exp_valid = (m == 1'b0) && (ref_weighted_sum(ds, 1'b0) % 10 == 0);
        exp_check = (m == 1'b1) ? 4'((10 - ref_weighted_sum(ds, 1'b1) % 10) % 10) : 4'd0;
        check_eq("finish_gap_done", done, 0);
        check_eq("finish_gap_busy", busy, 1);
        @(negedge CLOCK_50);
        check_eq("res_done", done, 1);
        check_eq("res_busy", busy, 0);
        check_eq("res_valid", valid, exp_valid);
        check_eq("res_check", check_digit, exp_check);
        check_eq("res_error", error, 0);
        check_eq("res_err_code", err_code, 0);
        check_eq("res_count", digit_count, ds.size());
    endtask

    task automatic run_number(input bit m, input int ds[$]);
        do_start(m);
        send_stream(ds);
        finish_checks(m, ds);
    endtask

    task automatic expect_error(input string tag, input logic [1:0] code, input int cnt);
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_error"}, error, 1);
        check_eq({tag, "_code"}, err_code, code);
        check_eq({tag, "_valid"}, valid, 0);
        check_eq({tag, "_check"}, check_digit, 0);
        check_eq({tag, "_ready"}, digit_ready, 0);
        check_eq({tag, "_count"}, digit_count, cnt);
    endtask

    initial begin
        int ds[$];
        int len;
        int bad;

        repeat (3) @(negedge CLOCK_50);
        check_eq("reset_outs", all_outs(), 0);
        RESET_N = 1'b1;
        @(negedge CLOCK_50);
        check_eq("idle_ready", digit_ready, 0);

        ds = '{7, 9, 9, 2, 7, 3, 9, 8, 7, 1, 3};
        run_number(1'b0, ds);
        check_eq("ex_valid", valid, 1);

        // Digits offered in DONE must be ignored.
        digit_valid = 1'b1;
        digit       = 4'd5;
        repeat (3) @(negedge CLOCK_50);
        digit_valid = 1'b0;
        check_eq("done_hold_count", digit_count, 11);
        check_eq("done_hold_done", done, 1);

        ds = '{7, 9, 9, 2, 7, 3, 9, 8, 7, 1, 0};
        run_number(1'b0, ds);
        check_eq("ex_bad_valid", valid, 0);

        ds = '{7, 9, 9, 2, 7, 3, 9, 8, 7, 1};
        run_number(1'b1, ds);
        check_eq("ex_gen_check", check_digit, 3);

        do_start(1'b0);
        send_digit(4'd4, 1'b0);
        send_digit(4'd5, 1'b0);
        send_digit(4'hA, 1'b0);
        expect_error("bad_digit", 2'd1, 3);

        do_start(1'b0);
        for (int i = 0; i < MAX_DIGITS; i++) send_digit(4'($urandom_range(0, 9)), 1'b0);
        expect_error("too_long", 2'd3, MAX_DIGITS);
        digit_valid = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        digit_valid = 1'b0;
        check_eq("too_long_20th", digit_count, MAX_DIGITS);

        do_start(1'b1);
        send_digit(4'd7, 1'b1);
        expect_error("too_short", 2'd2, 1);

        // Abort after five digits, restart in VERIFY.
        do_start(1'b1);
        for (int i = 0; i < 5; i++) send_digit(4'($urandom_range(0, 9)), 1'b0);
        ds = '{7, 9, 9, 2, 7, 3, 9, 8, 7, 1, 3};
        run_number(1'b0, ds);
        check_eq("abort_valid", valid, 1);

        // start and digit_valid together: the digit must not be taken.
        start       = 1'b1;
        mode        = 1'b0;
        digit_valid = 1'b1;
        digit       = 4'd5;
        digit_last  = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        start       = 1'b0;
        digit_valid = 1'b0;
        digit_last  = 1'b0;
        check_eq("coincide_count", digit_count, 0);
        check_eq("coincide_done", done, 0);
        send_stream(ds);
        finish_checks(1'b0, ds);

        // Asynchronous reset mid-stream.
        do_start(1'b0);
        for (int i = 0; i < 3; i++) send_digit(4'($urandom_range(0, 9)), 1'b0);
        #3 RESET_N = 1'b0;
        #1 check_eq("async_reset_outs", all_outs(), 0);
        repeat (2) @(negedge CLOCK_50);
        RESET_N     = 1'b1;
        digit_valid = 1'b1;
        digit_last  = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        digit_valid = 1'b0;
        digit_last  = 1'b0;
        check_eq("post_reset_outs", all_outs(), 0);

        for (int it = 0; it < 40; it++) begin
            bit m;
            m   = 1'($urandom);
            len = $urandom_range(MIN_DIGITS, MAX_DIGITS);
            ds.delete();
            for (int i = 0; i < len; i++) ds.push_back($urandom_range(0, 9));
            run_number(m, ds);
        end

        for (int it = 0; it < 10; it++) begin
            len = $urandom_range(MIN_DIGITS, MAX_DIGITS);
            bad = $urandom_range(0, len - 1);
            do_start(1'($urandom));
            for (int i = 0; i <= bad; i++) begin
                if (i == bad) send_digit(4'($urandom_range(10, 15)), i == len - 1);
                else          send_digit(4'($urandom_range(0, 9)), 1'b0);
            end
            expect_error("rand_bad", 2'd1, bad + 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
